// File: rtl/mig_app_pkg.sv
// rtl/mig_app_pkg.sv - shared constants, types and LFSR step for the MIG app-interface responder
package mig_app_pkg;

    localparam logic [2:0]  CMD_WRITE  = 3'd0;
    localparam logic [2:0]  CMD_READ   = 3'd1;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam int          FIFO_DEPTH = 4;
    localparam int          FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        CAL_BUSY = 1'b0,
        CAL_DONE = 1'b1
    } cal_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mig_app_responder_if.sv
// rtl/mig_app_responder_if.sv - MIG 7-series app_* command, write-data and read-data bundle
interface mig_app_responder_if #(
    parameter int DATA_W = 128
);
    logic                  app_en;
    logic [2:0]            app_cmd;
    logic [27:0]           app_addr;
    logic                  app_rdy;
    logic                  app_wdf_wren;
    logic [DATA_W-1:0]     app_wdf_data;
    logic [DATA_W/8-1:0]   app_wdf_mask;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [DATA_W-1:0]     app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;

    modport master (
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_data, app_wdf_mask, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/app_sync_fifo.sv
// rtl/app_sync_fifo.sv - small single-clock FIFO with occupancy count; DEPTH must be a power of two
module app_sync_fifo
    import mig_app_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             ui_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count < CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge ui_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mig_app_responder.sv
// rtl/mig_app_responder.sv - on-chip RAM stand-in for MIG + DDR3 behind the app_* user interface
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int MEM_AW       = 10,
    parameter int DATA_W       = 128,
    parameter int CALIB_CYCLES = 64,
    parameter int RD_LAT       = 8,
    parameter bit STALL_EN     = 1'b1
) (
    input  logic       ui_clk,
    input  logic       rst_n,
    output logic       ui_clk_sync_rst,
    output logic       init_calib_complete,
    output logic [7:0] err_cnt,
    mig_app_responder_if.slave app
);

    localparam int MW     = DATA_W / 8;
    localparam int WDAT_W = DATA_W + MW;

    logic [1:0]        sync_sr;
    cal_state_t        cal_state, cal_state_nx;
    logic [15:0]       cal_cnt, cal_cnt_nx;
    logic              calib_done;
    logic [15:0]       lfsr;
    logic              stall_c, stall_w;

    logic [FIFO_CW-1:0] wcmd_cnt, wdat_cnt;
    logic [MEM_AW-1:0]  wcmd_dout;
    logic [WDAT_W-1:0]  wdat_dout;
    logic [DATA_W-1:0]  wdata;
    logic [MW-1:0]      wmask;
    logic               cmd_acc, wcmd_push, rcmd_acc, wdat_push, commit;
    logic [MEM_AW-1:0]  word_idx;
    logic               addr_unused;

    logic [DATA_W-1:0]  mem [2**MEM_AW];
    logic               rd_v0;
    logic [MEM_AW-1:0]  rd_idx0;
    logic [DATA_W-1:0]  rd_ram_q;
    logic [RD_LAT:1]    rd_v;
    logic [DATA_W-1:0]  rd_d [2:RD_LAT];

    logic               e_cmd, e_aln, e_end;
    logic [8:0]         err_sum;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) sync_sr <= 2'b11;
        else        sync_sr <= {sync_sr[0], 1'b0};
    end
    assign ui_clk_sync_rst = sync_sr[1];

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_state <= CAL_BUSY;
            cal_cnt   <= '0;
        end else begin
            cal_state <= cal_state_nx;
            cal_cnt   <= cal_cnt_nx;
        end
    end

    always_comb begin
        cal_state_nx = cal_state;
        cal_cnt_nx   = cal_cnt;
        case (cal_state)
            CAL_BUSY: begin
                if (!ui_clk_sync_rst) begin
                    if (cal_cnt == 16'(CALIB_CYCLES - 1)) cal_state_nx = CAL_DONE;
                    else                                  cal_cnt_nx   = cal_cnt + 16'd1;
                end
            end
            CAL_DONE: cal_state_nx = CAL_DONE;
            default:  cal_state_nx = CAL_BUSY;
        endcase
    end

    assign calib_done          = (cal_state == CAL_DONE);
    assign init_calib_complete = calib_done;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    assign stall_c = STALL_EN && (lfsr[2:0] == 3'd0);
    assign stall_w = STALL_EN && (lfsr[5:3] == 3'd0);

    // Commands wait while a write command lacks its data, so reads cannot overtake writes
    assign app.app_rdy     = calib_done && !stall_c && (wcmd_cnt < FIFO_CW'(FIFO_DEPTH))
                             && (wcmd_cnt <= wdat_cnt);
    assign app.app_wdf_rdy = calib_done && !stall_w && (wdat_cnt < FIFO_CW'(FIFO_DEPTH));

    assign word_idx    = app.app_addr[MEM_AW+2:3];
    assign addr_unused = ^app.app_addr[27:MEM_AW+3];
    assign cmd_acc     = app.app_en && app.app_rdy;
    assign wcmd_push   = cmd_acc && (app.app_cmd == CMD_WRITE);
    assign rcmd_acc    = cmd_acc && (app.app_cmd == CMD_READ);
    assign wdat_push   = app.app_wdf_wren && app.app_wdf_rdy;
    assign commit      = (wcmd_cnt != '0) && (wdat_cnt != '0);

    app_sync_fifo #(.WIDTH(MEM_AW), .DEPTH(FIFO_DEPTH)) u_wcmd_fifo (
        .ui_clk    (ui_clk),
        .rst_n     (rst_n),
        .push      (wcmd_push),
        .push_data (word_idx),
        .pop       (commit),
        .pop_data  (wcmd_dout),
        .count     (wcmd_cnt)
    );

    app_sync_fifo #(.WIDTH(WDAT_W), .DEPTH(FIFO_DEPTH)) u_wdat_fifo (
        .ui_clk    (ui_clk),
        .rst_n     (rst_n),
        .push      (wdat_push),
        .push_data ({app.app_wdf_data, app.app_wdf_mask}),
        .pop       (commit),
        .pop_data  (wdat_dout),
        .count     (wdat_cnt)
    );

    assign wdata = wdat_dout[WDAT_W-1:MW];
    assign wmask = wdat_dout[MW-1:0];

    // RAM is read one cycle after acceptance so a commit on the acceptance edge is already visible
    always_ff @(posedge ui_clk) begin
        if (commit) begin
            for (int b = 0; b < MW; b++) begin
                if (!wmask[b]) mem[wcmd_dout][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rd_ram_q <= mem[rd_idx0];
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v0   <= 1'b0;
            rd_idx0 <= '0;
            rd_v    <= '0;
            for (int i = 2; i <= RD_LAT; i++) rd_d[i] <= '0;
        end else begin
            rd_v0   <= rcmd_acc;
            rd_idx0 <= word_idx;
            rd_v[1] <= rd_v0;
            rd_d[2] <= rd_ram_q;
            for (int i = 2; i <= RD_LAT; i++) rd_v[i] <= rd_v[i-1];
            for (int i = 3; i <= RD_LAT; i++) rd_d[i] <= rd_d[i-1];
        end
    end

    assign app.app_rd_data       = rd_d[RD_LAT];
    assign app.app_rd_data_valid = rd_v[RD_LAT];
    assign app.app_rd_data_end   = rd_v[RD_LAT];

    assign e_cmd   = cmd_acc && (app.app_cmd != CMD_WRITE) && (app.app_cmd != CMD_READ);
    assign e_aln   = cmd_acc && (app.app_addr[2:0] != 3'd0);
    assign e_end   = wdat_push && !app.app_wdf_end;
    assign err_sum = {1'b0, err_cnt} + {8'd0, e_cmd} + {8'd0, e_aln} + {8'd0, e_end};

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n)                err_cnt <= 8'd0;
        else if (err_sum > 9'd255) err_cnt <= 8'hFF;
        else                       err_cnt <= err_sum[7:0];
    end

endmodule

// File: tb/tb_mig_app_responder.sv
// tb/tb_mig_app_responder.sv - directed bench for mig_app_responder with and without ready stalls
module tb_mig_app_responder;
    import mig_app_pkg::*;

    localparam int DW = 128;

    logic ui_clk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 ui_clk = ~ui_clk;

    mig_app_responder_if #(.DATA_W(DW)) if0 ();
    mig_app_responder_if #(.DATA_W(DW)) if1 ();

    logic       sync0, calib0, sync1, calib1;
    logic [7:0] err0, err1;

    mig_app_responder #(.MEM_AW(10), .DATA_W(DW), .CALIB_CYCLES(64), .RD_LAT(8), .STALL_EN(1'b0)) dut0 (
        .ui_clk(ui_clk), .rst_n(rst_n), .ui_clk_sync_rst(sync0),
        .init_calib_complete(calib0), .err_cnt(err0), .app(if0)
    );

    mig_app_responder #(.MEM_AW(10), .DATA_W(DW), .CALIB_CYCLES(64), .RD_LAT(8), .STALL_EN(1'b1)) dut1 (
        .ui_clk(ui_clk), .rst_n(rst_n), .ui_clk_sync_rst(sync1),
        .init_calib_complete(calib1), .err_cnt(err1), .app(if1)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int got1   = 0;

    localparam logic [127:0] D2 = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] D3 = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
    localparam logic [127:0] D4 = 128'h5555AAAA5555AAAA_3333CCCC3333CCCC;
    localparam logic [127:0] DX = 128'hDEADBEEF00112233_4455667789ABCDEF;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ui_clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [31:0] w;
        w = 32'h9E3779B9 * (i + 1);
        return {w, ~w, w ^ 32'h0F0F0F0F, w + 32'd7};
    endfunction

    task automatic write0(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
        logic c_ok, d_ok, c_done, d_done;
        c_done = 1'b0;
        d_done = 1'b0;
        if0.app_en = 1'b1; if0.app_cmd = CMD_WRITE; if0.app_addr = addr;
        if0.app_wdf_wren = 1'b1; if0.app_wdf_end = 1'b1;
        if0.app_wdf_data = data; if0.app_wdf_mask = mask;
        for (int t = 0; t < 50 && !(c_done && d_done); t++) begin
            c_ok = if0.app_rdy && !c_done;
            d_ok = if0.app_wdf_rdy && !d_done;
            step();
            if (c_ok) begin c_done = 1'b1; if0.app_en = 1'b0; end
            if (d_ok) begin d_done = 1'b1; if0.app_wdf_wren = 1'b0; if0.app_wdf_end = 1'b0; end
        end
        if0.app_en = 1'b0; if0.app_wdf_wren = 1'b0; if0.app_wdf_end = 1'b0;
        if (!(c_done && d_done)) chk("write accepted", {c_done, d_done}, 2'b11);
    endtask

    task automatic wait_rd(input string tag, input int exp_lat, input logic [127:0] exp);
        int lat;
        lat = 99;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (if0.app_rd_data_valid) begin lat = t; break; end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, if0.app_rd_data, exp);
        chk({tag, " end"}, if0.app_rd_data_end, if0.app_rd_data_valid);
    endtask

    task automatic read0(input string tag, input logic [27:0] addr, input logic [127:0] exp);
        logic ok;
        ok = 1'b0;
        if0.app_en = 1'b1; if0.app_cmd = CMD_READ; if0.app_addr = addr;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = if0.app_rdy;
            step();
        end
        if0.app_en = 1'b0;
        if (!ok) chk({tag, " read accepted"}, ok, 1'b1);
        wait_rd(tag, 8, exp);
    endtask

    initial begin
        int  n;
        logic early_rdy;
        if0.app_en = 0; if0.app_cmd = 0; if0.app_addr = 0; if0.app_wdf_wren = 0;
        if0.app_wdf_data = 0; if0.app_wdf_mask = 0; if0.app_wdf_end = 0;
        if1.app_en = 0; if1.app_cmd = 0; if1.app_addr = 0; if1.app_wdf_wren = 0;
        if1.app_wdf_data = 0; if1.app_wdf_mask = 0; if1.app_wdf_end = 0;

        // Reset values and calibration timing
        repeat (3) step();
        chk("rst sync_rst", sync0, 1'b1);
        chk("rst calib", calib0, 1'b0);
        chk("rst app_rdy", if0.app_rdy, 1'b0);
        chk("rst wdf_rdy", if0.app_wdf_rdy, 1'b0);
        chk("rst rd_valid", if0.app_rd_data_valid, 1'b0);
        chk("rst rd_data", if0.app_rd_data, 128'h0);
        chk("rst err_cnt", err0, 8'd0);
        rst_n = 1'b1;
        n = 99;
        for (int t = 1; t <= 10; t++) begin
            step();
            if (!sync0) begin n = t; break; end
        end
        chk("sync_rst cycles after release", n, 2);
        n = 999;
        early_rdy = 1'b0;
        for (int t = 1; t <= 200; t++) begin
            step();
            if (calib0) begin n = t; break; end
            if (if0.app_rdy || if0.app_wdf_rdy) early_rdy = 1'b1;
        end
        chk("calib cycles", n, 64);
        chk("ready before calib", early_rdy, 1'b0);
        chk("app_rdy at calib", if0.app_rdy, 1'b1);
        chk("wdf_rdy at calib", if0.app_wdf_rdy, 1'b1);

        // Basic write then read
        write0(28'h40, D2, 16'h0000);
        step();
        read0("t2", 28'h40, D2);

        // Byte mask merge
        write0(28'h80, {128{1'b1}}, 16'h0000);
        write0(28'h80, 128'h0, 16'hFF00);
        read0("t3", 28'h80, D3);

        // Command ahead of its data holds off a following read
        if0.app_en = 1'b1; if0.app_cmd = CMD_WRITE; if0.app_addr = 28'hC0;
        chk("t4 rdy idle", if0.app_rdy, 1'b1);
        step();
        if0.app_cmd = CMD_READ;
        for (int t = 0; t < 3; t++) begin
            chk("t4 rdy held", if0.app_rdy, 1'b0);
            step();
        end
        if0.app_wdf_wren = 1'b1; if0.app_wdf_end = 1'b1; if0.app_wdf_data = D4; if0.app_wdf_mask = 16'h0;
        chk("t4 wdf_rdy", if0.app_wdf_rdy, 1'b1);
        chk("t4 rdy before data", if0.app_rdy, 1'b0);
        step();
        if0.app_wdf_wren = 1'b0; if0.app_wdf_end = 1'b0;
        chk("t4 rdy after data", if0.app_rdy, 1'b1);
        step();
        if0.app_en = 1'b0;
        wait_rd("t4", 8, D4);

        // Protocol errors and address aliasing
        if0.app_en = 1'b1; if0.app_cmd = 3'd2; if0.app_addr = 28'h100;
        step();
        if0.app_en = 1'b0;
        chk("err bad cmd", err0, 8'd1);
        write0(28'h43, DX, 16'h0000);
        chk("err misaligned", err0, 8'd2);
        read0("t6 truncated", 28'h40, DX);
        read0("t6 alias", 28'h2040, DX);
        chk("err after alias", err0, 8'd2);

        // Back-to-back reads return back-to-back
        if0.app_en = 1'b1; if0.app_cmd = CMD_READ; if0.app_addr = 28'h80;
        step();
        if0.app_addr = 28'h40;
        step();
        if0.app_en = 1'b0;
        wait_rd("b2b first", 7, D3);
        step();
        chk("b2b second valid", if0.app_rd_data_valid, 1'b1);
        chk("b2b second data", if0.app_rd_data, DX);

        // Reset during an in-flight read
        if0.app_en = 1'b1; if0.app_cmd = CMD_READ; if0.app_addr = 28'h40;
        step();
        if0.app_en = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("mid rst sync_rst", sync0, 1'b1);
        chk("mid rst err_cnt", err0, 8'd0);
        chk("mid rst calib", calib0, 1'b0);
        rst_n = 1'b1;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (if0.app_rd_data_valid) n++;
        end
        chk("valid pulses after reset", n, 0);
        n = 0;
        for (int t = 0; t < 200 && !(calib0 && calib1); t++) step();
        chk("recalibrated", {calib0, calib1}, 2'b11);
        read0("ram retained", 28'h40, DX);

        // Stalled interface: 64 writes then 64 reads
        fork
            begin
                logic acc;
                if1.app_en = 1'b1;
                for (int i = 0; i < 128; i++) begin
                    if1.app_cmd  = (i < 64) ? CMD_WRITE : CMD_READ;
                    if1.app_addr = 28'((i % 64) * 8);
                    for (int t = 0; t < 200; t++) begin
                        acc = if1.app_rdy;
                        step();
                        if (acc) break;
                    end
                end
                if1.app_en = 1'b0;
            end
            begin
                logic acc;
                if1.app_wdf_wren = 1'b1; if1.app_wdf_end = 1'b1; if1.app_wdf_mask = 16'h0;
                for (int i = 0; i < 64; i++) begin
                    if1.app_wdf_data = pat(i);
                    for (int t = 0; t < 200; t++) begin
                        acc = if1.app_wdf_rdy;
                        step();
                        if (acc) break;
                    end
                end
                if1.app_wdf_wren = 1'b0; if1.app_wdf_end = 1'b0;
            end
            begin
                for (int c = 0; c < 4000 && got1 < 64; c++) begin
                    step();
                    if (if1.app_rd_data_valid) begin
                        chk("stall data", if1.app_rd_data, pat(got1));
                        got1++;
                    end
                end
            end
        join
        repeat (12) step();
        chk("stall no extra beats", if1.app_rd_data_valid, 1'b0);
        chk("stall beats", got1, 64);
        chk("stall err_cnt", err1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mig_app_responder.md
Name: mig_app_responder

Overview:
Synthesizable responder for the MIG 7-series user (app_*) interface. It is the other end of the DDR3 read/write controller: it accepts commands and write data and returns read data from a small on-chip RAM.
- Used in simulation and in on-board loopback builds, replacing MIG and the external DDR3.
- Models the calibration delay, ready back-pressure and fixed read latency.

Parameters:
- MEM_AW, 10, RAM depth is 2^MEM_AW words of DATA_W; word index = app_addr[MEM_AW+2:3]
- DATA_W, 128, app data width (4:1 ratio, BL8, x16 device)
- CALIB_CYCLES, 64, cycles from reset release to init_calib_complete
- RD_LAT, 8, cycles from read-command acceptance to app_rd_data_valid (minimum 2)
- STALL_EN, 1, enables pseudo-random deassertion of app_rdy and app_wdf_rdy

Ports:
- ui_clk  in  1  user clock
- rst_n  in  1  reset; asynchronous, active-low
- ui_clk_sync_rst  out  1  high while rst_n is low and for 2 cycles after release
- init_calib_complete  out  1  calibration-done flag
- app_en  in  1  command valid
- app_cmd  in  3  command: 0 = write, 1 = read
- app_addr  in  28  byte/column address; BL8-aligned
- app_rdy  out  1  command ready
- app_wdf_wren  in  1  write data valid
- app_wdf_data  in  DATA_W  write data
- app_wdf_mask  in  DATA_W/8  byte mask; 1 = byte not written
- app_wdf_end  in  1  last beat of burst; must equal app_wdf_wren
- app_wdf_rdy  out  1  write data ready
- app_rd_data  out  DATA_W  read data
- app_rd_data_valid  out  1  read data valid
- app_rd_data_end  out  1  equals app_rd_data_valid
- err_cnt  out  8  saturating protocol-error counter

Behaviour:
Reset values:
- All outputs 0, except ui_clk_sync_rst = 1.
- FIFOs, latency pipe, calibration counter and err_cnt are cleared.
- RAM contents are retained.
- LFSR is loaded with 16'hACE1.

Calibration:
- Counter starts after ui_clk_sync_rst falls.
- init_calib_complete is registered and rises exactly CALIB_CYCLES cycles later.
- It then stays high until the next reset.

Ready signals:
- app_rdy = calib_done & !stall_c & (wcmd_cnt < 4) & (wcmd_cnt <= wdat_cnt).
- The last term holds off all commands while any write command is still waiting for its data, so a read can never overtake a pending write.
- app_wdf_rdy = calib_done & !stall_w & (wdat_cnt < 4).
- With STALL_EN: stall_c = (lfsr[2:0] == 0) and stall_w = (lfsr[5:3] == 0).
- LFSR uses taps x^16+x^14+x^13+x^11+1 and advances every cycle. With STALL_EN = 0 both stall terms are 0.

Command acceptance (app_en & app_rdy):
- cmd 0: push the word index into the write-command FIFO (depth 4).
- cmd 1: read the RAM at the word index and push into the RD_LAT-deep valid/data pipe.
- Any other cmd: dropped, err_cnt increments.
- app_addr[2:0] != 0: err_cnt increments; address is still used, truncated to alignment.
- Address bits above MEM_AW+2 are ignored, so addresses alias. This is not an error.

Write data:
- app_wdf_wren & app_wdf_rdy pushes {data, mask} into the write-data FIFO (depth 4).
- Data may arrive before, with, or after its command.
- wren & !end: err_cnt increments.

Commit:
- When both write FIFOs are non-empty, pop one entry from each and write the RAM with byte enables ~mask, one commit per cycle.
- The RAM write is visible to a read accepted on the following cycle or later.

Read return:
- app_rd_data_valid pulses exactly RD_LAT cycles after acceptance, one beat per command, in order.
- Back-to-back reads return back-to-back; there is no read back-pressure.

Simultaneous events:
- Command acceptance, data push and commit may all occur in the same cycle.
- FIFO counts are updated as push minus pop.

Other:
- err_cnt saturates at 255.
- Reset mid-operation: pending writes are discarded and in-flight read data is dropped, with no valid pulse.

Decomposition:
- Package mig_app_pkg: CMD_WRITE = 3'd0, CMD_READ = 3'd1, LFSR_SEED, LFSR tap mask, FIFO_DEPTH = 4.
- One sub-module, app_sync_fifo (parameterised width, depth 4, count output), instantiated twice: write-command FIFO and write-data FIFO.

Test Plan:
1. Reset release with STALL_EN = 0 -> init_calib_complete rises at cycle 64 after ui_clk_sync_rst falls; app_rdy and app_wdf_rdy rise on the same cycle.
2. Write addr 0x40 with data 0x0123..CDEF, mask 0; read addr 0x40 two cycles later -> app_rd_data_valid exactly 8 cycles after the read is accepted, data matches.
3. Write with mask 16'hFF00 over a word previously written as all-ones with new data 0 -> readback has upper 8 bytes = 0xFF.., lower 8 bytes = 0x00.
4. Write command issued 3 cycles before its data -> app_rdy stays 0 until the data is accepted; a queued read then returns the new data.
5. STALL_EN = 1 with the controller doing 64 back-to-back writes then 64 reads -> all data matches, no valid beat is lost, err_cnt = 0.
6. app_cmd = 3'd2 once, then app_addr = 0x43 once -> err_cnt = 2; assert rst_n low mid-read -> no app_rd_data_valid pulse after reset.
